serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor: computes a - b LSB-first using a single

---
 rtl/serial_subtractor.sv | 155 +++++++++++++++
 tb/tb_serial_subtractor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : serial_subtractor                                          |
// | Description : Bit-serial two's-complement subtractor. Computes a - b     |
// |               LSB-first with one full-subtractor cell and a registered   |
// |               borrow, one bit per clock, behind a start/busy/done        |
// |               handshake.                                                 |
// | Ports       : clk, rst (async, active-high)                              |
// |               start      - request, sampled only in IDLE                 |
// |               a, b       - minuend / subtrahend, captured on accept      |
// |               busy       - high while in RUN and DONE                    |
// |               done       - one-cycle pulse, result valid                 |
// |               diff       - a - b mod 2^WIDTH, held until next accept     |
// |               borrow_out - unsigned a < b, held with diff                |
// |               ovf        - signed overflow, held with diff               |
// | Option      : define SERIAL_SUB_OVF_EN to drive ovf; otherwise ovf is 0  |
// |               and no operand sign bits are kept.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_br;
    logic [WIDTH-1:0]   r_diff;
    logic               r_busy;
    logic               r_done;
    logic               r_borrow;

    logic w_accept;
    logic w_run_last;
    logic w_d;
    logic w_br_nxt;

    // Full-subtractor cell on the current operand LSBs.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_accept   = (r_state == c_IDLE) && start;
    assign w_run_last = (r_state == c_RUN) && (r_cnt == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_br     <= 1'b0;
            r_diff   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_br     <= 1'b0;
                        r_cnt    <= '0;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_nxt;
                    // Result bits enter at the MSB so the word is LSB-aligned
                    // after exactly WIDTH shifts.
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_cnt  <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        // Outputs are registered, so the pulse and the final
                        // borrow are loaded on the edge that enters DONE.
                        r_borrow <= w_br_nxt;
                        r_done   <= 1'b1;
                        r_state  <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    // Operand sign bits are shifted out during RUN, so they are kept aside
    // at accept for the overflow decision on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_ovf   <= 1'b0;
        end else if (w_run_last) begin
            // w_d is the final diff MSB being shifted in on this edge.
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign ovf = r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_accept ^ w_run_last;
    assign ovf          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_subtractor                                       |
// | Description : Self-checking bench for serial_subtractor (WIDTH=8):       |
// |               vector table, random operands against an arithmetic        |
// |               model, held-start, back-to-back and mid-run reset cases.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_subtractor;

    localparam int WIDTH = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit c_OVF_EN = 1'b1;
`else
    localparam bit c_OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    int n_vec = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vdiff;
        logic       vbrw;
        logic       vovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                         output logic [7:0] md, output logic mbr, output logic mov);
        int ua, ub, sa, sb, sr;
        ua  = int'(ma);
        ub  = int'(mb);
        sa  = int'($signed(ma));
        sb  = int'($signed(mb));
        sr  = sa - sb;
        md  = 8'((ua - ub + 256) % 256);
        mbr = (ua < ub);
        mov = c_OVF_EN && ((sr > 127) || (sr < -128));
    endtask

    // Issues one operation from IDLE, returns the result and the number of
    // edges after the accept edge until done was seen.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         output logic [7:0] gd, output logic gbr, output logic gov,
                         output int lat);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        gd  = diff;
        gbr = borrow_out;
        gov = ovf;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("diff_held", 32'(diff), 32'(gd));
    endtask

    vec_t       tbl [8];
    logic [7:0] gd, ed;
    logic       gbr, gov, ebr, eov;
    int         lat;
    int         busy_cnt, done_cnt;
    logic [7:0] held_d;
    logic       held_b;

    initial begin
        tbl[0] = '{8'h05, 8'h0F, 8'hF6, 1'b1, 1'b0};
        tbl[1] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[5] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
        tbl[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Table vectors (these run back-to-back: each next start lands in
        // the IDLE cycle right after DONE).
        for (int i = 0; i < 8; i++) begin
            do_op(tbl[i].va, tbl[i].vb, gd, gbr, gov, lat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(WIDTH));
            chk($sformatf("tbl%0d_diff", i), 32'(gd), 32'(tbl[i].vdiff));
            chk($sformatf("tbl%0d_borrow", i), 32'(gbr), 32'(tbl[i].vbrw));
            chk($sformatf("tbl%0d_ovf", i), 32'(gov), 32'(c_OVF_EN & tbl[i].vovf));
        end

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ra, rb, ed, ebr, eov);
            do_op(ra, rb, gd, gbr, gov, lat);
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(WIDTH));
            chk($sformatf("rnd%0d_diff_%02h_%02h", i, ra, rb), 32'(gd), 32'(ed));
            chk($sformatf("rnd%0d_borrow", i), 32'(gbr), 32'(ebr));
            chk($sformatf("rnd%0d_ovf", i), 32'(gov), 32'(eov));
        end

        // start held high with operands changing every cycle.
        busy_cnt = 0; done_cnt = 0; held_d = '0; held_b = 1'b0;
        @(negedge clk);
        a = 8'h05; b = 8'h0F; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                held_d = diff;
                held_b = borrow_out;
                start  = 1'b0;
            end
            a = 8'($urandom);
            b = 8'($urandom);
        end
        start = 1'b0;
        chk("hold_busy_cycles", 32'(busy_cnt), 32'd9);
        chk("hold_done_pulses", 32'(done_cnt), 32'd1);
        chk("hold_diff", 32'(held_d), 32'hF6);
        chk("hold_borrow", 32'(held_b), 32'd1);
        chk("hold_diff_stable", 32'(diff), 32'hF6);

        // Explicit back-to-back pair.
        do_op(8'h10, 8'h20, gd, gbr, gov, lat);
        chk("b2b_first_diff", 32'(gd), 32'hF0);
        do_op(8'h00, 8'h01, gd, gbr, gov, lat);
        chk("b2b_latency", 32'(lat), 32'(WIDTH));
        chk("b2b_diff", 32'(gd), 32'hFF);
        chk("b2b_borrow", 32'(gbr), 32'd1);

        // Reset in the 4th RUN cycle.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        do_op(8'h10, 8'h01, gd, gbr, gov, lat);
        chk("after_abort_latency", 32'(lat), 32'(WIDTH));
        chk("after_abort_diff", 32'(gd), 32'h0F);
        chk("after_abort_borrow", 32'(gbr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
